// File: rtl/skew_pkg.sv
// Shared definitions for the skew/deskew delay buffer: the mode encoding and
// the per-lane delay rule.
package skew_pkg;

    typedef enum logic {
        SKEW   = 1'b0,
        DESKEW = 1'b1
    } skew_mode_e;

    // Delay in en-cycles of a lane: a rising staircase in SKEW, falling in DESKEW.
    function automatic int unsigned lane_delay(
        input int unsigned lane,
        input skew_mode_e  mode,
        input int unsigned base,
        input int unsigned channels
    );
        return (mode == SKEW) ? (base + lane) : (base + channels - 1 - lane);
    endfunction

endpackage

// File: rtl/delay_lane.sv
// One lane of the skew buffer: a DEPTH-deep shift register of {valid, data}
// with a runtime-selected output tap.
module delay_lane #(
    parameter int unsigned BITS  = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAP_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [TAP_W-1:0] tap,
    input  logic             in_valid,
    input  logic [BITS-1:0]  d,
    output logic [BITS-1:0]  q,
    output logic             out_valid,
    output logic             busy
);

    typedef struct packed {
        logic            valid;
        logic [BITS-1:0] data;
    } stage_t;

    stage_t stage [DEPTH];

    // NOTE: the stages are ordinary flops, not a RAM, and the reset value of
    // every stage is visible on q, so every stage is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
        end else if (en) begin
            // NOTE: non-blocking assignments make every stage read its
            // neighbour's old value, so loop order does not matter.
            stage[0] <= '{valid: in_valid, data: d};
            for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
        end
    end

    // NOTE: defaults first so no path through the mux leaves q unassigned,
    // which would infer a latch.
    always_comb begin
        q         = '0;
        out_valid = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap == TAP_W'(k)) begin
                q         = stage[k].data;
                out_valid = stage[k].valid;
            end
        end
    end

    // Busy covers the whole lane, including stages beyond the current tap.
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < DEPTH; k++) busy = busy | stage[k].valid;
    end

endmodule

// File: rtl/skew_delay_buffer.sv
// Multi-lane staircase delay buffer: skews rows into a systolic array or
// re-aligns its outputs, with the mode switched only while drained.
module skew_delay_buffer
    import skew_pkg::*;
#(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned BITS     = 8,
    parameter int unsigned BASE     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     mode,
    input  logic                     in_valid,
    input  logic [CHANNELS*BITS-1:0] d,
    output logic [CHANNELS*BITS-1:0] q,
    output logic [CHANNELS-1:0]      out_valid,
    output logic                     busy,
    output logic                     mode_active
);

    localparam int unsigned MAXD  = BASE + CHANNELS - 1;
    localparam int unsigned TAP_W = (MAXD > 1) ? $clog2(MAXD) : 1;

    skew_mode_e          mode_q;
    logic [CHANNELS-1:0] lane_busy;

    assign busy        = |lane_busy;
    assign mode_active = mode_q;

    // A new mode is accepted only when no valid word is in flight anywhere,
    // or when the same edge flushes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= SKEW;
        end else if (!busy || clr) begin
            mode_q <= skew_mode_e'(mode);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        localparam int unsigned D_SKEW   = lane_delay(i, SKEW, BASE, CHANNELS);
        localparam int unsigned D_DESKEW = lane_delay(i, DESKEW, BASE, CHANNELS);

        logic [TAP_W-1:0] tap;

        // The tap is one stage short of the delay: stage 0 is loaded by the
        // accepting edge itself.
        assign tap = (mode_q == SKEW) ? TAP_W'(D_SKEW - 1) : TAP_W'(D_DESKEW - 1);

        delay_lane #(
            .BITS  (BITS),
            .DEPTH (MAXD),
            .TAP_W (TAP_W)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .clr       (clr),
            .tap       (tap),
            .in_valid  (in_valid),
            .d         (d[i*BITS +: BITS]),
            .q         (q[i*BITS +: BITS]),
            .out_valid (out_valid[i]),
            .busy      (lane_busy[i])
        );
    end

endmodule
